// File: rtl/btn_pkg.sv
// Shared definitions for the front-panel button controller: FSM state
// encoding, default timing constants and small constant-evaluation helpers.
package btn_pkg;

    // Event FSM state encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS    = 2'd1,
        LONG     = 2'd2,
        WAIT_REL = 2'd3
    } btn_state_e;

    // Defaults sized for a 27 MHz system clock (~9.7 ms sample period).
    localparam int DEF_SAMPLE_DIV   = 262144;
    localparam int DEF_LONG_TICKS   = 100;
    localparam int DEF_REPEAT_TICKS = 20;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Ceiling log2 clamped to at least one bit, for index ports.
    function automatic int width_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    // Index of the lowest set bit among the first n bits (0 when none set).
    function automatic int lowest_set(input logic [31:0] vec, input int n);
        int idx;
        idx = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_sample_filt.sv
// Key conditioning front end: two-flop synchroniser, shared sample tick
// divider and a per-key two-sample debounce filter. btn_level changes only
// when two consecutive tick samples agree; tick_d marks the cycle in which
// the freshly filtered level is visible.
module btn_sample_filt
    import btn_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic             tick_d
);

    localparam int              DIV_W    = clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] samp_q, samp_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_d_q, tick_d_d;
    logic             tick_s;
    logic [N_BTN-1:0] synced_s;
    logic [N_BTN-1:0] agree_s;

    // Next-state logic for synchroniser, divider and debounce filter.
    always_comb begin
        synced_s = ~sync2_q;
        tick_s   = (div_cnt_q == DIV_LAST);
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        tick_d_d = tick_s;
        agree_s  = ~(synced_s ^ samp_q);
        samp_d   = samp_q;
        level_d  = level_q;
        if (tick_s) begin
            div_cnt_d = {DIV_W{1'b0}};
            samp_d    = synced_s;
            level_d   = (agree_s & synced_s) | (~agree_s & level_q);
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= {N_BTN{1'b0}};
            sync2_q   <= {N_BTN{1'b0}};
            samp_q    <= {N_BTN{1'b0}};
            level_q   <= {N_BTN{1'b0}};
            div_cnt_q <= {DIV_W{1'b0}};
            tick_d_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            samp_q    <= samp_d;
            level_q   <= level_d;
            div_cnt_q <= div_cnt_d;
            tick_d_q  <= tick_d_d;
        end
    end

    assign btn_level = level_q;
    assign tick_d    = tick_d_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Front-panel button controller: debounces N_BTN active-low keys and runs a
// single arbitrated event FSM producing short-press, long-press and
// auto-repeat pulses. The first key pressed owns the FSM until every key is
// released. Optional macro BTN_AUTO_REPEAT_EN enables auto-repeat pulses in
// the long-held state; without it repeat_pulse is constant 0.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_BTN-1:0]               btn_n,
    output logic [N_BTN-1:0]               btn_level,
    output logic [N_BTN-1:0]               short_pulse,
    output logic [N_BTN-1:0]               long_pulse,
    output logic [N_BTN-1:0]               repeat_pulse,
    output logic [width_min1(N_BTN)-1:0]   owner,
    output logic                           busy
);

    localparam int               OWN_W     = width_min1(N_BTN);
    localparam int               HOLD_W    = clog2(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [N_BTN-1:0] ONE_S     = N_BTN'(1'b1);

    logic [N_BTN-1:0]  btn_level_s;
    logic              tick_d_s;
    logic [N_BTN-1:0]  owner_oh_s;

    btn_state_e        state_q, state_d;
    logic [OWN_W-1:0]  owner_q, owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_BTN-1:0]  short_q, short_d;
    logic [N_BTN-1:0]  long_q, long_d;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int              REP_W    = clog2(REPEAT_TICKS) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [N_BTN-1:0]  repeat_q, repeat_d;
`endif

    btn_sample_filt #(
        .N_BTN      (N_BTN),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_filt (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .btn_level (btn_level_s),
        .tick_d    (tick_d_s)
    );

    // Event FSM: next state, counters and one-cycle pulse requests.
    always_comb begin
        owner_oh_s = ONE_S << owner_q;
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        short_d    = {N_BTN{1'b0}};
        long_d     = {N_BTN{1'b0}};
`ifdef BTN_AUTO_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        repeat_d   = {N_BTN{1'b0}};
`endif
        if (tick_d_s) begin
            case (state_q)
                IDLE: begin
                    if (btn_level_s != {N_BTN{1'b0}}) begin
                        owner_d    = OWN_W'(lowest_set(32'(btn_level_s), N_BTN));
                        hold_cnt_d = {HOLD_W{1'b0}};
                        state_d    = PRESS;
                    end else begin
                        state_d    = IDLE;
                    end
                end
                PRESS: begin
                    if (!btn_level_s[owner_q]) begin
                        short_d = owner_oh_s;
                        state_d = WAIT_REL;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        long_d    = owner_oh_s;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_cnt_d = {REP_W{1'b0}};
`endif
                        state_d   = LONG;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                LONG: begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (!btn_level_s[owner_q]) begin
                        state_d = WAIT_REL;
                    end else if (rep_cnt_q == REP_LAST) begin
                        repeat_d  = owner_oh_s;
                        rep_cnt_d = {REP_W{1'b0}};
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`else
                    if (!btn_level_s[owner_q]) begin
                        state_d = WAIT_REL;
                    end else begin
                        state_d = LONG;
                    end
`endif
                end
                WAIT_REL: begin
                    if (btn_level_s == {N_BTN{1'b0}}) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_REL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state, owner, counters and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= {OWN_W{1'b0}};
            hold_cnt_q <= {HOLD_W{1'b0}};
            short_q    <= {N_BTN{1'b0}};
            long_q     <= {N_BTN{1'b0}};
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_q  <= {REP_W{1'b0}};
            repeat_q   <= {N_BTN{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            short_q    <= short_d;
            long_q     <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
            repeat_q   <= repeat_d;
`endif
        end
    end

    assign btn_level    = btn_level_s;
    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = {N_BTN{1'b0}};
`endif
    assign owner        = owner_q;
    assign busy         = (state_q != IDLE);

endmodule
